demux16_collect: RTL and testbench
==================================

# demux16_collect

Sequential 1-to-16 bit demultiplexer and word collector: the inverse of the team's 16:1 bit-select muxes. It accepts single bits addressed by a 4-bit select and places each bit at that position of a 16-bit collection register. Once all 16 positions have been written, it presents the assembled word on a valid/ready output through a one-entry holding register. It sits on the receive side of bit-serial or bit-scattered links and feeds word-wide consumers.

## Interface
- No parameters; widths are fixed by package constants (16-bit word, 4-bit select).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_bit  input  1  data bit to place.
- in_sel  input  4  target bit position (0..15).
- in_valid  input  1  in_bit/in_sel valid this cycle.
- in_ready  output  1  block can accept a bit this cycle.
- out_word  output  16  assembled word; bit i was written with in_sel == i.
- out_valid  output  1  out_word holds an undelivered word.
- out_ready  input  1  consumer accepts out_word this cycle.
- fill_mask  output  16  bit i set once position i of the word in collection has been written.
- overwrite  output  1  one-cycle pulse: the accepted bit targeted an already-filled position.

## Operation
- Accept: in_valid && in_ready at a clock edge. On accept, coll[in_sel] <= in_bit and fill_mask[in_sel] <= 1.
- in_ready = (fill_mask != 16'hFFFF). Combinational from state only; it never depends on in_valid.
- Overwrite: accepting to a position whose mask bit is already set replaces the data bit. The mask is unchanged, and overwrite pulses high for the next cycle.
- Transfer: at an edge where fill_mask == 16'hFFFF and (!out_valid || out_ready):
  - out_word <= coll and out_valid <= 1.
  - coll and fill_mask are cleared to 0.
- Output handshake: at an edge where out_valid && out_ready and no transfer occurs, out_valid <= 0. out_word holds its last value.
- Stall: while the collection is full and the holding register is occupied without out_ready, in_ready stays 0 and all state holds.
- Simultaneous drain and transfer at the same edge: the new word replaces out_word and out_valid stays 1, with no bubble.
- Reset: all state is cleared at the next edge and any partial word is discarded. Reset values:
  - out_word = 0, out_valid = 0, fill_mask = 0, overwrite = 0.
  - in_ready = 1 (follows from the empty mask).

## Timing
- Latency: the last missing bit is accepted at edge k; the transfer occurs at edge k+1 if the output slot is free; out_valid is high from edge k+1.
- Bubble: in_ready is 0 for exactly one cycle after a word completes when the slot is free.
- Sustained throughput: one word per 17 cycles with back-to-back distinct selects and out_ready held at 1.
- The holding register lets collection of the next word proceed while out_valid waits on out_ready.
- overwrite is registered; it is high in the cycle after the offending accept.

## Configuration
- Macro: DEMUX16_COLLECT_AUTO_SEL_EN.
- Defined:
  - in_sel is ignored. An internal 4-bit pointer supplies the position, starting at 0.
  - The pointer increments on each accept and wraps from 15 to 0.
  - Bits fill in order 0..15, overwrite is tied to 0, and transfer and reset behaviour are unchanged.
  - Reset clears the pointer to 0.
- Undefined: positions come from in_sel exactly as described in Operation; no pointer is instantiated.

## Structure
- Package demux16_pkg holds:
  - WORD_W = 16 and SEL_W = 4.
  - FULL_MASK = 16'hFFFF.
  - typedefs word_t (logic [15:0]) and sel_t (logic [3:0]).
- Sub-module demux16_decode: a combinational 4-to-16 one-hot decoder with an enable. It drives the per-bit write enables for coll and fill_mask, so the main block holds only registers and the transfer/handshake logic.

## Test plan
- Basic: after reset, accept sel 0..15 with in_bit = sel[0], out_ready = 1 → out_valid at edge k+1, out_word = 16'hAAAA, fill_mask returns to 0.
- Out-of-order: write sel 15 down to 0 with bits from 16'h1234 → out_word = 16'h1234; in_ready 0 for exactly one cycle.
- Overwrite: write sel 3 = 1, then sel 3 = 0, then fill the rest with 1 → overwrite pulses once; out_word = 16'hFFF7.
- Back-pressure: out_ready = 0, complete two words (16'h00FF, then 16'hFF00):
  - in_ready stays 0 after the second completes and out_word holds 16'h00FF.
  - Raising out_ready for one cycle yields 16'hFF00 with out_valid continuously 1.
- Reset mid-word: after 9 accepts, assert rst for one cycle → fill_mask = 0, out_valid = 0; the next 16 accepts produce only the new word.
- With DEMUX16_COLLECT_AUTO_SEL_EN: drive random in_sel with bits of 16'hBEEF in order 0..15 → out_word = 16'hBEEF and overwrite never asserts.

Source files
------------

// File: rtl/demux16_pkg.sv
// ---------------------------------------------------------------------------
// demux16_pkg
// Shared widths and types for the 1-to-16 bit demultiplexer / word collector.
//   WORD_W    : assembled word width (16)
//   SEL_W     : bit-position select width (4)
//   FULL_MASK : fill mask value meaning every position has been written
//   word_t    : 16-bit word / mask type
//   sel_t     : 4-bit position type
// ---------------------------------------------------------------------------
package demux16_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SEL_W  = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;

    localparam word_t FULL_MASK = 16'hFFFF;

endpackage : demux16_pkg

// File: rtl/demux16_decode.sv
// ---------------------------------------------------------------------------
// demux16_decode
// Combinational 4-to-16 one-hot decoder with enable. Produces the per-bit
// write enables for the collection register and fill mask.
// Ports:
//   en_i     : enable; when low the output is all zeros
//   sel_i    : bit position to select
//   onehot_o : one-hot write enable, bit sel_i set when en_i is high
// ---------------------------------------------------------------------------
module demux16_decode
    import demux16_pkg::*;
(
    input  logic              en_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [WORD_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule : demux16_decode

// File: rtl/demux16_collect.sv
// ---------------------------------------------------------------------------
// demux16_collect
// Sequential 1-to-16 bit demultiplexer and word collector. Single bits are
// placed at their addressed position of a 16-bit collection register; once
// all 16 positions are written the word moves into a one-entry holding
// register presented on a valid/ready output.
//
// Configuration macro: DEMUX16_COLLECT_AUTO_SEL_EN
//   defined   : in_sel is ignored; an internal pointer (reset to 0,
//               incrementing per accept, wrapping 15->0) supplies the
//               position and overwrite is tied low.
//   undefined : positions come from in_sel.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_bit    : data bit to place
//   in_sel    : target bit position
//   in_valid  : in_bit/in_sel valid this cycle
//   in_ready  : block can accept a bit (collection not full)
//   out_word  : assembled word
//   out_valid : out_word holds an undelivered word
//   out_ready : consumer accepts out_word this cycle
//   fill_mask : positions already written in the word being collected
//   overwrite : registered pulse, previous accept hit a filled position
// ---------------------------------------------------------------------------
module demux16_collect
    import demux16_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] fill_mask,
    output logic              overwrite
);

    word_t coll_q, coll_d;
    word_t mask_q, mask_d;
    word_t word_q, word_d;
    logic  valid_q, valid_d;

    logic  full;
    logic  accept;
    logic  transfer;
    sel_t  pos;
    word_t we;

    assign full     = (mask_q == FULL_MASK);
    assign accept   = in_valid && !full;
    // Transfer only when the collection is complete; accept and transfer are
    // therefore mutually exclusive at any edge.
    assign transfer = full && (!valid_q || out_ready);

`ifdef DEMUX16_COLLECT_AUTO_SEL_EN
    sel_t ptr_q, ptr_d;
    logic unused_sel;

    assign unused_sel = ^in_sel;
    assign pos        = ptr_q;
    assign ptr_d      = accept ? sel_t'(ptr_q + 1'b1) : ptr_q;
    assign overwrite  = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic ovw_q, ovw_d;

    assign pos       = in_sel;
    assign ovw_d     = |(mask_q & we);
    assign overwrite = ovw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovw_q <= 1'b0;
        end else begin
            ovw_q <= ovw_d;
        end
    end
`endif

    demux16_decode u_decode (
        .en_i     (accept),
        .sel_i    (pos),
        .onehot_o (we)
    );

    always_comb begin
        coll_d  = coll_q;
        mask_d  = mask_q;
        word_d  = word_q;
        valid_d = valid_q;
        if (transfer) begin
            // A drain at the same edge is absorbed: valid stays high.
            word_d  = coll_q;
            valid_d = 1'b1;
            coll_d  = '0;
            mask_d  = '0;
        end else begin
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
            coll_d = (coll_q & ~we) | (we & {WORD_W{in_bit}});
            mask_d = mask_q | we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q  <= '0;
            mask_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            coll_q  <= coll_d;
            mask_q  <= mask_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = !full;
    assign out_word  = word_q;
    assign out_valid = valid_q;
    assign fill_mask = mask_q;

endmodule : demux16_collect

// File: tb/tb_demux16_collect.sv
// ---------------------------------------------------------------------------
// tb_demux16_collect
// Self-checking bench for demux16_collect: a per-position reference model,
// a table of whole-word vectors, hand-written corner sequences and a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_demux16_collect;
    import demux16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_bit;
    logic [3:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] fill_mask;
    logic        overwrite;

    int total = 0;
    int bad   = 0;

    // Reference model: one bit and one written-flag per position, plus the
    // delivered word slot.
    bit          m_bits   [16];
    bit          m_filled [16];
    logic [15:0] m_word;
    bit          m_valid;
    bit          m_ovw;
    int          m_ptr;

    demux16_collect dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill_mask (fill_mask),
        .overwrite (overwrite)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += m_filled[i];
        return n;
    endfunction

    function automatic logic [15:0] m_mask();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m_filled[i];
        return r;
    endfunction

    function automatic logic [15:0] m_data();
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m_bits[i];
        return r;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_bits[i]   = 1'b0;
            m_filled[i] = 1'b0;
        end
        m_word  = '0;
        m_valid = 1'b0;
        m_ovw   = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock: drive inputs, compare outputs against the model, advance the
    // model, then step past the edge.
    task automatic cycle(input logic r, input logic v, input logic b,
                         input logic [3:0] s, input logic rd);
        bit full;
        int pos;
        rst       = r;
        in_valid  = v;
        in_bit    = b;
        in_sel    = s;
        out_ready = rd;
        #1;
        full = (m_count() == 16);
        chk("in_ready",  {15'd0, in_ready},  {15'd0, !full});
        chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
        chk("out_word",  out_word, m_word);
        chk("fill_mask", fill_mask, m_mask());
        chk("overwrite", {15'd0, overwrite}, {15'd0, m_ovw});
        if (r) begin
            m_clear();
        end else begin
`ifdef DEMUX16_COLLECT_AUTO_SEL_EN
            pos = m_ptr;
`else
            pos = int'(s);
`endif
            m_ovw = 1'b0;
            if (full && (!m_valid || rd)) begin
                m_word  = m_data();
                m_valid = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    m_bits[i]   = 1'b0;
                    m_filled[i] = 1'b0;
                end
            end else if (m_valid && rd) begin
                m_valid = 1'b0;
            end
            if (v && !full) begin
`ifndef DEMUX16_COLLECT_AUTO_SEL_EN
                m_ovw = m_filled[pos];
`endif
                m_bits[pos]   = b;
                m_filled[pos] = 1'b1;
                m_ptr         = (m_ptr + 1) % 16;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // order: 0 ascending, 1 descending, 2 random permutation
    task automatic feed(input logic [15:0] w, input int order, input logic rd);
        int seq [16];
        int j;
        int t;
        for (int i = 0; i < 16; i++) seq[i] = (order == 1) ? 15 - i : i;
        if (order == 2) begin
            for (int i = 15; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                t = seq[i]; seq[i] = seq[j]; seq[j] = t;
            end
        end
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, w[seq[i]], 4'(seq[i]), rd);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          order;
        logic [15:0] exp_word;
    } vec_t;

    vec_t vecs [5];
    int   pulses;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sel = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        m_clear();
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst_out_word",  out_word, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_fill_mask", fill_mask, 16'h0000);
        chk("rst_overwrite", {15'd0, overwrite}, 16'd0);
        chk("rst_in_ready",  {15'd0, in_ready}, 16'd1);

`ifndef DEMUX16_COLLECT_AUTO_SEL_EN
        vecs[0] = '{16'hAAAA, 0, 16'hAAAA};
        vecs[1] = '{16'h1234, 1, 16'h1234};
        vecs[2] = '{16'hC3A5, 2, 16'hC3A5};
        vecs[3] = '{16'h0000, 0, 16'h0000};
        vecs[4] = '{16'hFFFF, 1, 16'hFFFF};
        for (int n = 0; n < 5; n++) begin
            feed(vecs[n].data, vecs[n].order, 1'b1);
            chk("vec_bubble_ready", {15'd0, in_ready}, 16'd0);
            cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            chk("vec_valid", {15'd0, out_valid}, 16'd1);
            chk("vec_word",  out_word, vecs[n].exp_word);
            chk("vec_mask",  fill_mask, 16'h0000);
            chk("vec_ready_back", {15'd0, in_ready}, 16'd1);
        end
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Overwrite of position 3
        pulses = 0;
        cycle(1'b0, 1'b1, 1'b1, 4'd3, 1'b1);
        pulses += int'(overwrite);
        cycle(1'b0, 1'b1, 1'b0, 4'd3, 1'b1);
        chk("ovw_pulse", {15'd0, overwrite}, 16'd1);
        pulses += int'(overwrite);
        for (int i = 0; i < 16; i++) begin
            if (i != 3) begin
                cycle(1'b0, 1'b1, 1'b1, 4'(i), 1'b1);
                pulses += int'(overwrite);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulses += int'(overwrite);
        chk("ovw_count", 16'(pulses), 16'd1);
        chk("ovw_word",  out_word, 16'hFFF7);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        // Back-pressure: two words with out_ready low
        feed(16'h00FF, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("bp_first_valid", {15'd0, out_valid}, 16'd1);
        feed(16'hFF00, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
            chk("bp_stall_ready", {15'd0, in_ready}, 16'd0);
            chk("bp_stall_word",  out_word, 16'h00FF);
            chk("bp_stall_mask",  fill_mask, 16'hFFFF);
        end
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("bp_second_word",  out_word, 16'hFF00);
        chk("bp_second_valid", {15'd0, out_valid}, 16'd1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("bp_drained", {15'd0, out_valid}, 16'd0);

        // Reset mid-word
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1, 4'(i), 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("mid_rst_mask",  fill_mask, 16'h0000);
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        feed(16'h5A5A, 2, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("mid_rst_word",  out_word, 16'h5A5A);
        chk("mid_rst_valid2", {15'd0, out_valid}, 16'd1);
`else
        // Auto-pointer: random in_sel, bits of BEEF in order 0..15
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] beef;
            beef = 16'hBEEF;
            cycle(1'b0, 1'b1, beef[i], 4'($urandom), 1'b1);
            pulses += int'(overwrite);
        end
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        pulses += int'(overwrite);
        chk("auto_word",  out_word, 16'hBEEF);
        chk("auto_valid", {15'd0, out_valid}, 16'd1);
        chk("auto_ovw",   16'(pulses), 16'd0);
`endif

        // Randomized phase, every cycle compared against the model
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux16_collect
